// File: rtl/avmm_block_read_master.sv
// avmm_block_read_master
//   Avalon-MM read initiator that streams a contiguous block of words out of a
//   single-port on-chip RAM (registered address, unregistered q, no read
//   strobe). Words are buffered in a small FIFO and presented on a
//   valid/ready stream in address-issue order.
//
// Ports
//   clk, reset_n        : single clock, synchronous active-low reset
//   start               : 1-cycle block request, sampled only in IDLE
//   base_addr           : first word address
//   num_words           : words to read (0..1024, larger values clamp to 1024)
//   busy, done          : block in progress / 1-cycle completion pulse
//   mem_*               : Avalon-MM master side towards the RAM slave
//   st_data/valid/ready : output word stream

// Flags a push into a full buffer; the credit scheme must make this impossible.
module avmm_block_read_master_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic             clk,
  input logic             reset_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);
  // No write may land in a full FIFO unless a word leaves in the same cycle.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && !pop && (count == CNT_W'(FIFO_DEPTH))));
    end
  end
endmodule

module avmm_block_read_master #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_addr;        // address of the next issue
  logic [ADDR_W:0]         r_remaining;   // issues still to make
  logic                    r_busy;
  logic                    r_done;
  logic                    r_cs;
  logic [ADDR_W-1:0]       r_mem_address;
  logic [READ_LATENCY-1:0] r_pipe;        // one valid bit per outstanding read
  logic [CNT_W-1:0]        r_used;        // words issued but not yet popped
  logic [DATA_W-1:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_st_valid;

  logic                    w_pop;
  logic                    w_push;
  logic                    w_accept;
  logic                    w_issue;
  logic [ADDR_W:0]         w_num_clamped;
  logic [ADDR_W-1:0]       w_issue_addr;
  logic [ADDR_W:0]         w_issue_rem;
  logic [CNT_W-1:0]        w_used_next;
  logic [CNT_W-1:0]        w_count_next;

  assign w_pop         = r_st_valid & st_ready;
  assign w_push        = r_pipe[READ_LATENCY-1];
  assign w_num_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign w_accept      = (r_state == S_IDLE) && start && (num_words != (ADDR_W+1)'(0));
  // The first read goes out on the accepting edge; afterwards a read is issued
  // while issued-but-unpopped words leave room in the FIFO. A pop in the same
  // cycle is deliberately not credited, keeping the check a simple compare.
  assign w_issue       = w_accept || ((r_state == S_RUN) && (r_used < CNT_W'(FIFO_DEPTH)));
  assign w_issue_addr  = w_accept ? base_addr : r_addr;
  assign w_issue_rem   = w_accept ? w_num_clamped : r_remaining;
  assign w_used_next   = r_used + CNT_W'(w_issue) - CNT_W'(w_pop);
  assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_address    = r_mem_address;
  assign mem_chipselect = r_cs;
  assign mem_write      = 1'b0;
  assign mem_byteenable = {(DATA_W/8){1'b1}};
  assign mem_clken      = reset_n;
  assign st_data        = r_fifo[r_rd_ptr];
  assign st_valid       = r_st_valid;

  // Control FSM, read issue, latency pipe and output FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cs          <= 1'b0;
      r_mem_address <= '0;
      r_pipe        <= '0;
      r_used        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_st_valid    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_cs   <= w_issue;
      if (w_issue) begin
        r_mem_address <= w_issue_addr;
        r_addr        <= w_issue_addr + ADDR_W'(1);  // wraps at the top of the RAM
        r_remaining   <= w_issue_rem - (ADDR_W+1)'(1);
      end

      // The pipe output marks the cycle in which mem_readdata holds the word.
      r_pipe[0] <= r_cs;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      r_used <= w_used_next;

      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_readdata;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_next;
      r_st_valid <= (w_count_next != CNT_W'(0));

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_words == (ADDR_W+1)'(0)) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= (w_num_clamped == (ADDR_W+1)'(1)) ? S_DRAIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue && (r_remaining == (ADDR_W+1)'(1))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Zero used words means nothing in flight, buffered or unpopped.
          if (w_used_next == CNT_W'(0)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  avmm_block_read_master_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .count   (r_count)
  );
endmodule

// File: tb/tb_avmm_block_read_master.sv
// Directed bench for avmm_block_read_master with a behavioural RAM slave
// (registered address, unregistered q).
module tb_avmm_block_read_master;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW/8-1:0] mem_byteenable;
  logic [DW-1:0] mem_readdata;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  logic [AW-1:0] iss_q[$];
  logic [DW-1:0] st_q[$];

  logic [DW-1:0] ram [0:1023];
  logic [AW-1:0] ram_addr_q = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {6'h2B, a, 6'h15, ~a};
  endfunction

  // RAM slave model.
  always @(posedge clk) if (mem_clken) ram_addr_q <= mem_address;
  assign mem_readdata = ram[ram_addr_q];

  // Bus and stream monitor.
  always @(negedge clk) begin
    if (mem_chipselect) iss_q.push_back(mem_address);
    if (st_valid && st_ready) st_q.push_back(st_data);
    if (done) n_done++;
  end

  avmm_block_read_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_blk(input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (!done && k < limit) begin tick(); k++; end
    chk(tag, done, 1);
    tick(); tick();
  endtask

  // Compare captured addresses/words with the expected block starting at b.
  task automatic chk_block(input string tag, input logic [AW-1:0] b, input int n);
    int bad = 0;
    logic [AW-1:0] a;
    chk({tag, "_nissue"}, iss_q.size(), n);
    chk({tag, "_nwords"}, st_q.size(), n);
    a = b;
    for (int i = 0; i < n; i++) begin
      if (i < iss_q.size() && iss_q[i] !== a) bad++;
      if (i < st_q.size() && st_q[i] !== pat(a)) bad++;
      a = a + 10'd1;
    end
    chk({tag, "_order"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_tab [1:8];
    int d0, s0, i0;
    logic [DW-1:0] held;
    logic [AW-1:0] a1, a2;

    for (int i = 0; i < 1024; i++) ram[i] = pat(10'(i));

    // Reset state
    tick(); tick();
    chk("rst_ctl", {busy, done, mem_chipselect, st_valid, mem_clken, mem_write}, 6'b0);
    chk("rst_data", {mem_address, st_data}, 42'h0);
    chk("rst_be", mem_byteenable, 4'hF);
    reset_n = 1'b1;
    tick();
    chk("clken_run", mem_clken, 1);

    // Test 1: cycle-exact 4-word block from 0x010
    exp_tab[1] = 4'b1100; exp_tab[2] = 4'b1100; exp_tab[3] = 4'b1110; exp_tab[4] = 4'b1110;
    exp_tab[5] = 4'b0110; exp_tab[6] = 4'b0110; exp_tab[7] = 4'b0001; exp_tab[8] = 4'b0000;
    iss_q.delete(); st_q.delete(); d0 = n_done;
    start_blk(10'h010, 11'd4);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t1_cyc%0d_cs_busy_vld_done", k), {mem_chipselect, busy, st_valid, done}, exp_tab[k]);
      if (k <= 4) chk($sformatf("t1_addr%0d", k), mem_address, 10'h010 + 10'(k - 1));
      if (k >= 3 && k <= 6) chk($sformatf("t1_data%0d", k), st_data, pat(10'h010 + 10'(k - 3)));
      tick();
    end
    chk_block("t1", 10'h010, 4);
    chk("t1_done_cnt", n_done - d0, 1);

    // Test 2: address wrap at the top of the RAM
    iss_q.delete(); st_q.delete(); d0 = n_done;
    start_blk(10'h3FE, 11'd4);
    wait_done("t2_done", 50);
    chk_block("t2", 10'h3FE, 4);
    chk("t2_iss2", iss_q.size() > 2 ? iss_q[2] : 10'h3FF, 10'h000);

    // Test 3: back-pressure holds issues at FIFO depth
    iss_q.delete(); st_q.delete(); d0 = n_done;
    st_ready = 1'b0;
    start_blk(10'h100, 11'd8);
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (k == 5) held = st_data;
    end
    chk("t3_issues_stalled", iss_q.size(), 4);
    chk("t3_cs_low", mem_chipselect, 0);
    chk("t3_valid", st_valid, 1);
    chk("t3_head_held", held, pat(10'h100));
    chk("t3_head_now", st_data, pat(10'h100));
    st_ready = 1'b1;
    wait_done("t3_done", 100);
    chk_block("t3", 10'h100, 8);
    chk("t3_done_cnt", n_done - d0, 1);

    // Test 4a: zero-length request
    iss_q.delete(); st_q.delete(); d0 = n_done;
    start_blk(10'h040, 11'd0);
    chk("t4_zero_done", {done, busy, mem_chipselect}, 3'b100);
    tick();
    chk("t4_zero_after", {done, busy, mem_chipselect}, 3'b000);
    tick();
    chk("t4_zero_issues", iss_q.size(), 0);
    chk("t4_zero_done_cnt", n_done - d0, 1);

    // Test 4b: oversize request clamps to 1024 words
    iss_q.delete(); st_q.delete(); d0 = n_done;
    start_blk(10'h123, 11'd2000);
    wait_done("t4_big_done", 1300);
    chk_block("t4_big", 10'h123, 1024);
    a1 = iss_q.size() > 0 ? iss_q[iss_q.size() - 1] : 10'h000;
    chk("t4_big_last_addr", a1, 10'h122);
    chk("t4_big_done_cnt", n_done - d0, 1);

    // Test 5: start while busy is ignored
    iss_q.delete(); st_q.delete(); d0 = n_done;
    start_blk(10'h050, 11'd6);
    tick(); tick();
    start_blk(10'h3A0, 11'd2);
    wait_done("t5_done", 60);
    chk_block("t5", 10'h050, 6);
    chk("t5_done_cnt", n_done - d0, 1);
    chk("t5_idle", busy, 0);

    // Test 6: reset mid-block aborts it
    iss_q.delete(); st_q.delete(); d0 = n_done;
    start_blk(10'h200, 11'd6);
    i0 = 0;
    while (st_q.size() < 2 && i0 < 30) begin tick(); i0++; end
    chk("t6_two_words", st_q.size(), 2);
    st_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_rst_ctl", {busy, done, mem_chipselect, st_valid}, 4'b0);
    chk("t6_rst_data", {mem_address, st_data}, 42'h0);
    st_ready = 1'b1;
    s0 = st_q.size();
    for (int k = 0; k < 6; k++) tick();
    chk("t6_no_more_words", st_q.size(), s0);
    chk("t6_no_done", n_done - d0, 0);
    iss_q.delete(); st_q.delete(); d0 = n_done;
    start_blk(10'h300, 11'd3);
    wait_done("t6_new_done", 50);
    chk_block("t6_new", 10'h300, 3);
    chk("t6_new_done_cnt", n_done - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
